// File: rtl/mni_ack_rcv_pkg.sv
// Shared definitions for the MNI ack receiver: FSM state encoding, packet field
// positions and the saturating counter update.
package mni_ack_rcv_pkg;

    localparam int unsigned CNT_W   = 16;
    // Counter index field position inside W2.
    localparam int unsigned IDX_LSB = 2;

    // One-hot FSM states: five word slots, the update cycle, then notification hold.
    typedef enum logic [6:0] {
        StW0    = 7'b0000001,
        StW1    = 7'b0000010,
        StW2    = 7'b0000100,
        StW3    = 7'b0001000,
        StW4    = 7'b0010000,
        StUpd   = 7'b0100000,
        StNotif = 7'b1000000
    } state_t;

    // Counter minus ack value, clamped at zero.
    function automatic logic [CNT_W-1:0] sat_sub(input logic [CNT_W-1:0] cnt,
                                                input logic [CNT_W-1:0] val);
        return (cnt > val) ? (cnt - val) : '0;
    endfunction

endpackage

// File: rtl/mni_ack_rcv_if.sv
// Ack word stream, counter config port and notification handshake of the ack receiver.
// Signal prefixes are from the receiver's point of view.
interface mni_ack_rcv_if #(
    parameter int unsigned N_LOG = 4
) ();

    logic             i_ack_valid;
    logic [15:0]      i_ack_data;
    logic             o_ack_stall;
    logic             i_cfg_valid;
    logic [N_LOG-1:0] i_cfg_idx;
    logic [15:0]      i_cfg_data;
    logic             o_cfg_stall;
    logic [15:0]      o_cfg_rd_data;
    logic             o_notif_valid;
    logic [N_LOG-1:0] o_notif_idx;
    logic             i_notif_stall;
    logic             o_drop;

    // Ack source, config master and notification consumer.
    modport master (
        output i_ack_valid, i_ack_data, i_cfg_valid, i_cfg_idx, i_cfg_data, i_notif_stall,
        input  o_ack_stall, o_cfg_stall, o_cfg_rd_data, o_notif_valid, o_notif_idx, o_drop
    );

    // The ack receiver itself.
    modport slave (
        input  i_ack_valid, i_ack_data, i_cfg_valid, i_cfg_idx, i_cfg_data, i_notif_stall,
        output o_ack_stall, o_cfg_stall, o_cfg_rd_data, o_notif_valid, o_notif_idx, o_drop
    );

endinterface

// File: rtl/mni_ack_cnt_file.sv
// Completion counter file: 2^N_LOG x 16-bit counters, one shared write port
// (ack update has priority over preset), an update read port and a cfg read port.
module mni_ack_cnt_file
    import mni_ack_rcv_pkg::*;
#(
    parameter int unsigned N_LOG = 4
) (
    input  logic             clk_ni,
    input  logic             rst_ni,
    input  logic             i_upd_we,
    input  logic [N_LOG-1:0] i_upd_idx,
    input  logic [CNT_W-1:0] i_upd_data,
    output logic [CNT_W-1:0] o_upd_rd_data,
    input  logic             i_cfg_we,
    input  logic [N_LOG-1:0] i_cfg_idx,
    input  logic [CNT_W-1:0] i_cfg_data,
    output logic [CNT_W-1:0] o_cfg_rd_data
);

    localparam int unsigned N = 1 << N_LOG;

    logic [CNT_W-1:0] r_cnt [N];
    logic             w_we;
    logic [N_LOG-1:0] w_wr_idx;
    logic [CNT_W-1:0] w_wr_data;

    // Single write port: the update result wins over a preset.
    always_comb begin
        w_we      = i_upd_we | i_cfg_we;
        w_wr_idx  = i_upd_we ? i_upd_idx : i_cfg_idx;
        w_wr_data = i_upd_we ? i_upd_data : i_cfg_data;
    end

    // Counter storage.
    always_ff @(posedge clk_ni or posedge rst_ni) begin
        if (rst_ni) begin
            for (int i = 0; i < int'(N); i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_we) begin
            r_cnt[w_wr_idx] <= w_wr_data;
        end
    end

    assign o_upd_rd_data = r_cnt[i_upd_idx];
    assign o_cfg_rd_data = r_cnt[i_cfg_idx];

endmodule

// File: rtl/mni_ack_rcv.sv
// MNI ack receiver: parses 5-word ack packets, validates them against the local
// node and control region, decrements a completion counter and notifies on zero.
module mni_ack_rcv
    import mni_ack_rcv_pkg::*;
#(
    parameter int unsigned N_LOG = 4
) (
    input  logic          clk_ni,
    input  logic          rst_ni,
    input  logic [7:0]    i_board_id,
    input  logic [3:0]    i_node_id,
    input  logic [11:0]   i_ctl_addr_base,
    mni_ack_rcv_if.slave  bus
);

    state_t           r_state, w_state_nxt;
    logic             r_ok;
    logic [N_LOG-1:0] r_idx;
    logic [CNT_W-1:0] r_val;
    logic             r_notif_valid;
    logic [N_LOG-1:0] r_notif_idx;

    logic             w_ack_stall;
    logic             w_cfg_stall;
    logic             w_xfer;
    logic             w_word_ok;
    logic             w_upd_we;
    logic [CNT_W-1:0] w_upd_data;
    logic [CNT_W-1:0] w_upd_rd;
    logic             w_notif_set;
    logic             w_cfg_we;

    assign w_ack_stall = (r_state == StUpd) || (r_state == StNotif);
    assign w_cfg_stall = (r_state == StUpd);
    assign w_xfer      = bus.i_ack_valid & ~w_ack_stall;
    assign w_cfg_we    = bus.i_cfg_valid & ~w_cfg_stall;

    // Header check of the word currently on the bus, per word slot.
    always_comb begin
        w_word_ok = 1'b1;
        unique case (r_state)
            StW0:    w_word_ok = (bus.i_ack_data[11:0] == {i_board_id, i_node_id});
            StW1:    w_word_ok = (bus.i_ack_data == {i_ctl_addr_base, 4'b0000});
            StW2:    w_word_ok = (bus.i_ack_data[15:6] == '0) && (bus.i_ack_data[1:0] == '0);
            StW3:    w_word_ok = (bus.i_ack_data == '0);
            default: w_word_ok = 1'b1;
        endcase
    end

    // Next state, counter update and notification decision.
    always_comb begin
        w_state_nxt = r_state;
        w_upd_we    = 1'b0;
        w_upd_data  = sat_sub(w_upd_rd, r_val);
        w_notif_set = 1'b0;
        unique case (r_state)
            StW0:    if (w_xfer) w_state_nxt = StW1;
            StW1:    if (w_xfer) w_state_nxt = StW2;
            StW2:    if (w_xfer) w_state_nxt = StW3;
            StW3:    if (w_xfer) w_state_nxt = StW4;
            StW4:    if (w_xfer) w_state_nxt = StUpd;
            StUpd: begin
                w_upd_we    = r_ok;
                w_notif_set = r_ok && (w_upd_rd != '0) && (r_val >= w_upd_rd);
                w_state_nxt = w_notif_set ? StNotif : StW0;
            end
            StNotif: if (!bus.i_notif_stall) w_state_nxt = StW0;
            default: w_state_nxt = StW0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_ni or posedge rst_ni) begin
        if (rst_ni) begin
            r_state <= StW0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Packet capture: validity accumulates across W0..W3, index from W2, value from W4.
    always_ff @(posedge clk_ni or posedge rst_ni) begin
        if (rst_ni) begin
            r_ok  <= 1'b0;
            r_idx <= '0;
            r_val <= '0;
        end else if (w_xfer) begin
            if (r_state == StW0) begin
                r_ok <= w_word_ok;
            end else begin
                r_ok <= r_ok & w_word_ok;
            end
            if (r_state == StW2) begin
                r_idx <= bus.i_ack_data[IDX_LSB +: N_LOG];
            end
            if (r_state == StW4) begin
                r_val <= bus.i_ack_data;
            end
        end
    end

    // Notification register: set on update-to-zero, held until accepted.
    always_ff @(posedge clk_ni or posedge rst_ni) begin
        if (rst_ni) begin
            r_notif_valid <= 1'b0;
            r_notif_idx   <= '0;
        end else if (w_notif_set) begin
            r_notif_valid <= 1'b1;
            r_notif_idx   <= r_idx;
        end else if ((r_state == StNotif) && !bus.i_notif_stall) begin
            r_notif_valid <= 1'b0;
        end
    end

    mni_ack_cnt_file #(
        .N_LOG (N_LOG)
    ) u_cnt_file (
        .clk_ni        (clk_ni),
        .rst_ni        (rst_ni),
        .i_upd_we      (w_upd_we),
        .i_upd_idx     (r_idx),
        .i_upd_data    (w_upd_data),
        .o_upd_rd_data (w_upd_rd),
        .i_cfg_we      (w_cfg_we),
        .i_cfg_idx     (bus.i_cfg_idx),
        .i_cfg_data    (bus.i_cfg_data),
        .o_cfg_rd_data (bus.o_cfg_rd_data)
    );

    assign bus.o_ack_stall   = w_ack_stall;
    assign bus.o_cfg_stall   = w_cfg_stall;
    assign bus.o_notif_valid = r_notif_valid;
    assign bus.o_notif_idx   = r_notif_idx;
    assign bus.o_drop        = (r_state == StUpd) && !r_ok;

endmodule

// File: tb/tb_mni_ack_rcv.sv
// Self-checking bench for mni_ack_rcv: vector table of single packets plus
// hand-written sequences; notifications are checked through an expected-index queue.
module tb_mni_ack_rcv;

    localparam int unsigned N_LOG = 4;
    localparam logic [7:0]  BRD   = 8'hA5;
    localparam logic [3:0]  NOD   = 4'h3;
    localparam logic [11:0] BAS   = 12'h3C1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mni_ack_rcv_if #(.N_LOG(N_LOG)) bus ();

    mni_ack_rcv #(
        .N_LOG (N_LOG)
    ) dut (
        .clk_ni          (clk),
        .rst_ni          (rst),
        .i_board_id      (BRD),
        .i_node_id       (NOD),
        .i_ctl_addr_base (BAS),
        .bus             (bus)
    );

    typedef struct {
        logic [7:0]  board;
        logic [3:0]  node;
        logic [11:0] base;
        logic [3:0]  idx;
        logic [15:0] w2_or;
        logic [15:0] w3;
        logic        do_pre;
        logic [15:0] pre;
        logic [15:0] val;
        logic [15:0] exp_cnt;
        logic        exp_notif;
        logic        exp_drop;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] b, input logic [3:0] n, input logic [11:0] a,
                                input logic [3:0] i, input logic [15:0] w2o,
                                input logic [15:0] w3, input logic dp, input logic [15:0] p,
                                input logic [15:0] v, input logic [15:0] ec, input logic en,
                                input logic ed);
        vec_t r;
        r.board = b; r.node = n; r.base = a; r.idx = i; r.w2_or = w2o; r.w3 = w3;
        r.do_pre = dp; r.pre = p; r.val = v; r.exp_cnt = ec; r.exp_notif = en; r.exp_drop = ed;
        return r;
    endfunction

    // Notification consumer: each accepted notification must match the queue head.
    always @(negedge clk) begin
        if (!rst && bus.o_notif_valid && !bus.i_notif_stall) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL notif_unexpected: got idx %0d want none", bus.o_notif_idx);
            end else begin
                chk("notif_idx", 32'(bus.o_notif_idx), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    task automatic send_word(input logic [15:0] d);
        int n = 0;
        bus.i_ack_valid = 1'b1;
        bus.i_ack_data  = d;
        while (bus.o_ack_stall && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk("ack_stall_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        bus.i_ack_valid = 1'b0;
    endtask

    // Sends W0..W2 only; returns one cycle after W2 transfers.
    task automatic send_head(input logic [7:0] b, input logic [3:0] n, input logic [11:0] a,
                             input logic [3:0] i, input logic [15:0] w2o);
        send_word({4'b0000, b, n});
        send_word({a, 4'b0000});
        send_word({10'b0, i, 2'b00} | w2o);
    endtask

    // Full packet; returns during the Upd cycle.
    task automatic send_pkt(input logic [7:0] b, input logic [3:0] n, input logic [11:0] a,
                            input logic [3:0] i, input logic [15:0] w2o, input logic [15:0] w3,
                            input logic [15:0] v);
        send_head(b, n, a, i, w2o);
        send_word(w3);
        send_word(v);
    endtask

    task automatic preset(input logic [3:0] i, input logic [15:0] d);
        bus.i_cfg_valid = 1'b1;
        bus.i_cfg_idx   = i;
        bus.i_cfg_data  = d;
        @(posedge clk); #1;
        bus.i_cfg_valid = 1'b0;
    endtask

    initial begin
        bus.i_ack_valid   = 1'b0;
        bus.i_ack_data    = '0;
        bus.i_cfg_valid   = 1'b0;
        bus.i_cfg_idx     = '0;
        bus.i_cfg_data    = '0;
        bus.i_notif_stall = 1'b0;

        //           board node  base     idx  w2_or     w3     pre  preval    val        cnt      n  d
        vecs[0]  = mk(BRD, NOD,  BAS,     3,  16'h0,    16'h0, 1, 16'd100,  16'd40,    16'd60,  0, 0);
        vecs[1]  = mk(BRD, NOD,  BAS,     5,  16'h0,    16'h0, 1, 16'd64,   16'd64,    16'd0,   1, 0);
        vecs[2]  = mk(BRD, NOD,  BAS,     2,  16'h0,    16'h0, 1, 16'd10,   16'd30,    16'd0,   1, 0);
        vecs[3]  = mk(BRD, NOD,  BAS,     2,  16'h0,    16'h0, 0, 16'd0,    16'd5,     16'd0,   0, 0);
        vecs[4]  = mk(8'h5A, NOD, BAS,    7,  16'h0,    16'h0, 1, 16'd50,   16'd10,    16'd50,  0, 1);
        vecs[5]  = mk(BRD, NOD,  12'h3C2, 7,  16'h0,    16'h0, 0, 16'd0,    16'd10,    16'd50,  0, 1);
        vecs[6]  = mk(BRD, NOD,  BAS,     7,  16'h0,    16'h1, 0, 16'd0,    16'd10,    16'd50,  0, 1);
        vecs[7]  = mk(BRD, NOD,  BAS,     7,  16'h0001, 16'h0, 0, 16'd0,    16'd10,    16'd50,  0, 1);
        vecs[8]  = mk(BRD, NOD,  BAS,     7,  16'h0040, 16'h0, 0, 16'd0,    16'd10,    16'd50,  0, 1);
        vecs[9]  = mk(BRD, NOD,  BAS,     9,  16'h0,    16'h0, 1, 16'd9,    16'd0,     16'd9,   0, 0);
        vecs[10] = mk(BRD, NOD,  BAS,     15, 16'h0,    16'h0, 1, 16'hFFFF, 16'd1,     16'hFFFE, 0, 0);
        vecs[11] = mk(BRD, NOD,  BAS,     1,  16'h0,    16'h0, 1, 16'd1,    16'hFFFF,  16'd0,   1, 0);
        vecs[12] = mk(BRD, 4'h4, BAS,     1,  16'h0,    16'h0, 1, 16'd5,    16'd1,     16'd5,   0, 1);

        // Reset state
        #12;
        chk("rst_ack_stall", 32'(bus.o_ack_stall), 32'd0);
        chk("rst_cfg_stall", 32'(bus.o_cfg_stall), 32'd0);
        chk("rst_notif_valid", 32'(bus.o_notif_valid), 32'd0);
        chk("rst_notif_idx", 32'(bus.o_notif_idx), 32'd0);
        chk("rst_drop", 32'(bus.o_drop), 32'd0);
        chk("rst_cnt0", 32'(bus.o_cfg_rd_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Vector table
        for (int k = 0; k < 13; k++) begin
            bus.i_cfg_idx = vecs[k].idx;
            if (vecs[k].do_pre) begin
                preset(vecs[k].idx, vecs[k].pre);
                chk("preset_rd", 32'(bus.o_cfg_rd_data), 32'(vecs[k].pre));
            end
            send_pkt(vecs[k].board, vecs[k].node, vecs[k].base, vecs[k].idx, vecs[k].w2_or,
                     vecs[k].w3, vecs[k].val);
            chk("upd_drop", 32'(bus.o_drop), 32'(vecs[k].exp_drop));
            chk("upd_ack_stall", 32'(bus.o_ack_stall), 32'd1);
            chk("upd_notif_low", 32'(bus.o_notif_valid), 32'd0);
            if (vecs[k].exp_notif) exp_q.push_back(int'(vecs[k].idx));
            @(posedge clk); #1;
            chk("post_notif", 32'(bus.o_notif_valid), 32'(vecs[k].exp_notif));
            chk("post_cnt", 32'(bus.o_cfg_rd_data), 32'(vecs[k].exp_cnt));
            chk("post_drop", 32'(bus.o_drop), 32'd0);
            if (vecs[k].exp_notif) begin
                @(posedge clk); #1;
            end
        end
        bus.i_cfg_idx = 4'd3;
        #1;
        chk("ctr3_kept", 32'(bus.o_cfg_rd_data), 32'd60);

        // Stalled notification: stays stable, ack path stalled, presets still accepted
        bus.i_cfg_idx = 4'd5;
        preset(4'd5, 16'd64);
        bus.i_notif_stall = 1'b1;
        send_pkt(BRD, NOD, BAS, 4'd5, 16'h0, 16'h0, 16'd64);
        exp_q.push_back(5);
        @(posedge clk); #1;
        for (int c = 0; c < 4; c++) begin
            chk("stall_notif_valid", 32'(bus.o_notif_valid), 32'd1);
            chk("stall_notif_idx", 32'(bus.o_notif_idx), 32'd5);
            chk("stall_ack_stall", 32'(bus.o_ack_stall), 32'd1);
            chk("stall_cfg_stall", 32'(bus.o_cfg_stall), 32'd0);
            if (c == 1) preset(4'd6, 16'd7);
            else begin
                @(posedge clk); #1;
            end
        end
        bus.i_cfg_idx = 4'd6;
        #1;
        chk("notif_preset_rd", 32'(bus.o_cfg_rd_data), 32'd7);
        bus.i_notif_stall = 1'b0;
        @(posedge clk); #1;
        chk("release_notif", 32'(bus.o_notif_valid), 32'd0);
        chk("release_ack_stall", 32'(bus.o_ack_stall), 32'd0);

        // Preset during Upd is stalled and lands afterwards; preset to 0 raises nothing
        bus.i_cfg_idx = 4'd4;
        preset(4'd4, 16'd20);
        send_pkt(BRD, NOD, BAS, 4'd4, 16'h0, 16'h0, 16'd5);
        bus.i_cfg_valid = 1'b1;
        bus.i_cfg_data  = 16'd0;
        #1;
        chk("upd_cfg_stall", 32'(bus.o_cfg_stall), 32'd1);
        @(posedge clk); #1;
        chk("ack_wins_cnt", 32'(bus.o_cfg_rd_data), 32'd15);
        chk("after_upd_cfg_stall", 32'(bus.o_cfg_stall), 32'd0);
        @(posedge clk); #1;
        bus.i_cfg_valid = 1'b0;
        chk("late_preset_cnt", 32'(bus.o_cfg_rd_data), 32'd0);
        chk("preset0_no_notif", 32'(bus.o_notif_valid), 32'd0);

        // Reset mid-packet, then a complete packet
        bus.i_cfg_idx = 4'd8;
        preset(4'd8, 16'd30);
        send_head(BRD, NOD, BAS, 4'd8, 16'h0);
        rst = 1'b1;
        #1;
        chk("midrst_cnt", 32'(bus.o_cfg_rd_data), 32'd0);
        chk("midrst_ack_stall", 32'(bus.o_ack_stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        preset(4'd8, 16'd30);
        send_pkt(BRD, NOD, BAS, 4'd8, 16'h0, 16'h0, 16'd10);
        chk("midrst_upd_drop", 32'(bus.o_drop), 32'd0);
        @(posedge clk); #1;
        chk("midrst_cnt_after", 32'(bus.o_cfg_rd_data), 32'd20);
        @(posedge clk); #1;

        chk("notif_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
